instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001: Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst  input  1  synchronous, active-low reset; sampled only on rising edge of clk.
REQ-004: imem_req  output  1  instruction-memory read request.
REQ-005: imem_addr  output  32  word-aligned read address.
REQ-006: imem_ack  input  1  memory read complete; imem_rdata valid this cycle.
REQ-007: imem_rdata  input  32  instruction word returned by memory.
REQ-008: stall  input  1  decode/execute not ready; hold current instruction.
REQ-009: redirect  input  1  taken jump/branch from downstream control.
REQ-010: redirect_pc  input  32  jump/branch target.
REQ-011: instr  output  32  registered instruction word.
REQ-012: opcode  output  6  instr[31:26], drives decode/control opcode input.
REQ-013: funccode  output  6  instr[5:0], drives decode/control function-code input.
REQ-014: pc_out  output  32  address the current instr was fetched from.
REQ-015: pc_plus4  output  32  pc_out + 4, mod 2^32.
REQ-016: instr_valid  output  1  instr/opcode/funccode/pc_out valid for consumption.

Function
REQ-017: The FSM SHALL have exactly the states RESET_WAIT, FETCH and ISSUE.
REQ-018: RESET_WAIT SHALL last one cycle after rst deasserts, then go to FETCH; imem_req=0 in RESET_WAIT.
REQ-019: In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal the internal pc.
REQ-020: imem_addr SHALL stay stable while imem_req=1 and imem_ack=0; no request is abandoned before ack.
REQ-021: FETCH with imem_ack=1 and no redirect pending or present: instr<=imem_rdata, pc_out<=pc, instr_valid<=1, go to ISSUE.
REQ-022: In ISSUE, imem_req SHALL be 0 and instr, opcode, funccode, pc_out SHALL hold constant.
REQ-023: ISSUE with redirect=1: pc<=redirect_pc, instr_valid<=0, go to FETCH; redirect takes priority over stall.
REQ-024: ISSUE with redirect=0, stall=1: remain in ISSUE, all outputs unchanged.
REQ-025: ISSUE with redirect=0, stall=0: pc<=pc+4, instr_valid<=0, go to FETCH.
REQ-026: Redirect in FETCH without ack SHALL set a pending flag and store redirect_pc; a later redirect before ack overwrites the stored target (newest wins).
REQ-027: FETCH with imem_ack=1 and redirect=1 that cycle, or pending flag set: imem_rdata discarded, pc<=target, pending cleared, instr_valid stays 0, remain in FETCH. A same-cycle redirect_pc overrides the stored target.
REQ-028: redirect_pc[1:0] SHALL be forced to 2'b00 when loaded; pc[1:0] is always 0.
REQ-029: pc+4 SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 without error indication.
REQ-030: Minimum issue rate SHALL be one instruction per 2 cycles with zero-wait memory (ack in first FETCH cycle); each ack wait cycle adds one cycle.
REQ-031: opcode and funccode SHALL be combinational slices of the instr register, with no added latency.

Reset
REQ-032: rst=0 at a clock edge SHALL force: pc=RESET_PC, state=RESET_WAIT, pending=0, instr=0, pc_out=0, instr_valid=0, imem_req=0.
REQ-033: Reset asserted mid-FETCH SHALL drop imem_req the next cycle; a late imem_ack arriving in RESET_WAIT SHALL be ignored.
REQ-034: With rst held low, outputs SHALL remain at reset values; imem_addr=RESET_PC.

Verification
REQ-035: Reset release, memory acks in the first FETCH cycle, words 0x0000_0001, 0x0000_0002 at 0x0, 0x4 -> instr_valid high in cycles 3 and 5 after release, with pc_out=0x0 then 0x4 and funccode=6'h01 then 6'h02.
REQ-036: ack delayed 3 cycles -> imem_addr constant for 4 FETCH cycles, then instr captured and valid the next cycle.
REQ-037: ISSUE with stall=1 for 5 cycles, then redirect=1 with redirect_pc=0x0000_0103 -> outputs frozen for 5 cycles, next fetch at imem_addr=0x0000_0100.
REQ-038: Redirect to 0x40 in FETCH before ack, then redirect to 0x80, then ack -> data discarded, instr_valid stays 0, next fetch at 0x80.
REQ-039: pc=0xFFFF_FFFC issued, stall=0 -> next imem_addr=0x0000_0000, and pc_plus4=0x0000_0000 during issue.
REQ-040: rst asserted while imem_req=1, ack arriving during RESET_WAIT -> instr_valid stays 0, first fetch after reset at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   Instruction fetch stage. Walks a word-aligned program counter, issues
//   read requests to instruction memory, registers the returned word and
//   presents it to decode along with the address it came from. Downstream
//   control can hold the current instruction (stall) or steer the PC to a
//   new target (redirect). A redirect that arrives while a memory read is
//   still outstanding is remembered and applied once the read completes,
//   so a request is never abandoned mid-flight.
//
// Ports:
//   clk          single clock, all state updates on the rising edge
//   rst          synchronous active-low reset
//   imem_req     instruction-memory read request
//   imem_addr    word-aligned read address (the internal pc)
//   imem_ack     read complete, imem_rdata valid this cycle
//   imem_rdata   instruction word returned by memory
//   stall        decode/execute not ready, hold the current instruction
//   redirect     taken jump/branch from downstream control
//   redirect_pc  jump/branch target (low two bits are ignored)
//   instr        registered instruction word
//   opcode       instr[31:26]
//   funccode     instr[5:0]
//   pc_out       address the current instr was fetched from
//   pc_plus4     pc_out + 4, wrapping modulo 2^32
//   instr_valid  instr/opcode/funccode/pc_out valid for consumption
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funccode,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        instr_valid
);

    typedef enum logic [1:0] {
        RESET_WAIT,
        FETCH,
        ISSUE
    } state_t;

    // The pc must always be word aligned, so the reset value is masked too.
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        pending;
    logic        pending_next;
    logic [31:0] pend_target;
    logic [31:0] pend_target_next;
    logic [31:0] instr_next;
    logic [31:0] pc_out_next;
    logic        valid_next;
    logic [31:0] redirect_aligned;

    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

    // State register. Reset parks the FSM in RESET_WAIT so that the first
    // request only goes out one cycle after reset is released, which also
    // swallows any late ack belonging to a request cut off by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RESET_WAIT;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers: pc, pending redirect, and the issued instruction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= RESET_PC_ALIGNED;
            pending     <= 1'b0;
            pend_target <= 32'h0000_0000;
            instr       <= 32'h0000_0000;
            pc_out      <= 32'h0000_0000;
            instr_valid <= 1'b0;
        end else begin
            pc          <= pc_next;
            pending     <= pending_next;
            pend_target <= pend_target_next;
            instr       <= instr_next;
            pc_out      <= pc_out_next;
            instr_valid <= valid_next;
        end
    end

    // Next-state and next-value logic.
    // FETCH: hold the address until ack. If a redirect shows up before ack
    // it is latched (newest target wins); when ack finally arrives with a
    // redirect pending or present, the returned word belongs to the wrong
    // path and is dropped, and fetching restarts at the target.
    // ISSUE: redirect beats stall; otherwise stall holds everything and a
    // free cycle advances the pc by one word.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        pending_next     = pending;
        pend_target_next = pend_target;
        instr_next       = instr;
        pc_out_next      = pc_out;
        valid_next       = instr_valid;
        imem_req         = 1'b0;

        case (state)
            RESET_WAIT: begin
                state_next = FETCH;
            end

            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (redirect) begin
                        pc_next      = redirect_aligned;
                        pending_next = 1'b0;
                    end else if (pending) begin
                        pc_next      = pend_target;
                        pending_next = 1'b0;
                    end else begin
                        instr_next  = imem_rdata;
                        pc_out_next = pc;
                        valid_next  = 1'b1;
                        state_next  = ISSUE;
                    end
                end else if (redirect) begin
                    pending_next     = 1'b1;
                    pend_target_next = redirect_aligned;
                end
            end

            ISSUE: begin
                if (redirect) begin
                    pc_next    = redirect_aligned;
                    valid_next = 1'b0;
                    state_next = FETCH;
                end else if (!stall) begin
                    pc_next    = pc + 32'd4;
                    valid_next = 1'b0;
                    state_next = FETCH;
                end
            end

            default: begin
                state_next = RESET_WAIT;
            end
        endcase
    end

    assign imem_addr = pc;
    assign opcode    = instr[31:26];
    assign funccode  = instr[5:0];
    assign pc_plus4  = pc_out + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Purpose:
//   Self-checking bench for instr_fetch_unit. The main process plays the
//   role of instruction memory and downstream control with directed
//   vectors; every fetch it answers pushes the expected (pc, word) pair
//   into a scoreboard queue. A separate monitor pops that queue each time
//   the DUT presents a fresh instruction and compares all issue outputs.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funccode;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        instr_valid;

    int total_checks = 0;
    int pass_checks  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t sb_q[$];

    logic prev_valid = 1'b0;

    instr_fetch_unit #(
        .RESET_PC(RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .opcode      (opcode),
        .funccode    (funccode),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .instr_valid (instr_valid)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) begin
            pass_checks++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory side of one fetch: wait for the request (bounded), check the
    // address, hold ack off for 'delay' cycles while checking the address
    // stays put, then return 'data'. The expected issue goes to the queue.
    task automatic apply_stimulus(input logic [31:0] exp_addr, input logic [31:0] data,
                                  input int delay, input int max_wait);
        bit   found;
        exp_t e;
        found = 1'b0;
        for (int i = 0; i <= max_wait; i++) begin
            if (imem_req === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_output("req_seen", {31'b0, found}, 32'd1);
        check_output("fetch_addr", imem_addr, exp_addr);
        e.pc   = exp_addr;
        e.word = data;
        sb_q.push_back(e);
        for (int i = 0; i < delay; i++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            check_output("addr_stable", imem_addr, exp_addr);
            check_output("req_held", {31'b0, imem_req}, 32'd1);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'h0000_0000;
        check_output("issue_latency", {31'b0, instr_valid}, 32'd1);
    endtask

    // Monitor: a rising instr_valid marks a newly issued instruction.
    always @(negedge clk) begin
        exp_t e;
        if (instr_valid === 1'b1 && prev_valid !== 1'b1) begin
            if (sb_q.size() == 0) begin
                check_output("unexpected_issue", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check_output("sb_instr", instr, e.word);
                check_output("sb_pc_out", pc_out, e.pc);
                check_output("sb_opcode", {26'b0, opcode}, {26'b0, e.word[31:26]});
                check_output("sb_funccode", {26'b0, funccode}, {26'b0, e.word[5:0]});
                check_output("sb_pc_plus4", pc_plus4, e.pc + 32'd4);
            end
        end
        prev_valid = instr_valid;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] snap_instr;
        logic [31:0] snap_pc;

        rst         = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0000_0000;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0000_0000;
        @(negedge clk);

        // Reset held with noisy inputs: everything stays at reset values.
        imem_ack    = 1'b1;
        imem_rdata  = 32'hFFFF_FFFF;
        redirect    = 1'b1;
        redirect_pc = 32'h1234_5678;
        repeat (3) begin
            @(negedge clk);
            check_output("reset_req", {31'b0, imem_req}, 32'd0);
            check_output("reset_valid", {31'b0, instr_valid}, 32'd0);
            check_output("reset_addr", imem_addr, RESET_PC);
            check_output("reset_instr", instr, 32'h0000_0000);
            check_output("reset_pc_out", pc_out, 32'h0000_0000);
        end
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0000_0000;
        redirect    = 1'b0;
        redirect_pc = 32'h0000_0000;

        // Release: one RESET_WAIT cycle, then zero-wait fetches at 0x0, 0x4.
        rst = 1'b1;
        $display("[TB] reset released");
        check_output("reset_wait_req", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        apply_stimulus(32'h0000_0000, 32'h0000_0001, 0, 0);
        @(negedge clk);
        apply_stimulus(32'h0000_0004, 32'h0000_0002, 0, 0);
        @(negedge clk);

        // Ack delayed by three cycles.
        apply_stimulus(32'h0000_0008, 32'h8C41_0024, 3, 0);

        // Five stalled cycles, then a redirect to an unaligned target.
        stall      = 1'b1;
        snap_instr = instr;
        snap_pc    = pc_out;
        repeat (5) begin
            @(negedge clk);
            check_output("stall_instr", instr, snap_instr);
            check_output("stall_pc_out", pc_out, snap_pc);
            check_output("stall_valid", {31'b0, instr_valid}, 32'd1);
            check_output("stall_req", {31'b0, imem_req}, 32'd0);
        end
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clk);
        redirect    = 1'b0;
        redirect_pc = 32'h0000_0000;
        stall       = 1'b0;
        check_output("redirect_valid_drop", {31'b0, instr_valid}, 32'd0);
        apply_stimulus(32'h0000_0100, 32'h0000_0020, 0, 0);
        @(negedge clk);

        // Two redirects before ack: the read completes, is dropped, and the
        // newest target is fetched.
        check_output("pend_addr0", imem_addr, 32'h0000_0104);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        @(negedge clk);
        check_output("pend_addr1", imem_addr, 32'h0000_0104);
        redirect_pc = 32'h0000_0080;
        @(negedge clk);
        check_output("pend_addr2", imem_addr, 32'h0000_0104);
        redirect    = 1'b0;
        redirect_pc = 32'h0000_0000;
        imem_ack    = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0000_0000;
        check_output("pend_discard_valid", {31'b0, instr_valid}, 32'd0);
        apply_stimulus(32'h0000_0080, 32'h2001_0005, 0, 0);
        @(negedge clk);

        // Redirect in the same cycle as ack: data dropped, target aligned.
        check_output("same_cycle_addr", imem_addr, 32'h0000_0084);
        imem_ack    = 1'b1;
        imem_rdata  = 32'hBAD0_0BAD;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_01FE;
        @(negedge clk);
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0000_0000;
        redirect    = 1'b0;
        redirect_pc = 32'h0000_0000;
        check_output("same_cycle_valid", {31'b0, instr_valid}, 32'd0);
        apply_stimulus(32'h0000_01FC, 32'h0C00_0010, 0, 0);

        // Redirect from ISSUE to the top word, then wrap to zero.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        @(negedge clk);
        redirect    = 1'b0;
        redirect_pc = 32'h0000_0000;
        apply_stimulus(32'hFFFF_FFFC, 32'h1000_FFFF, 0, 0);
        check_output("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
        @(negedge clk);
        apply_stimulus(32'h0000_0000, 32'h0000_0008, 0, 0);
        @(negedge clk);

        // Reset while a request is outstanding; late ack in RESET_WAIT.
        check_output("pre_reset_req", {31'b0, imem_req}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check_output("mid_reset_req", {31'b0, imem_req}, 32'd0);
        check_output("mid_reset_valid", {31'b0, instr_valid}, 32'd0);
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hFACE_FACE;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'h0000_0000;
        check_output("late_ack_valid", {31'b0, instr_valid}, 32'd0);
        apply_stimulus(RESET_PC, 32'h0000_0033, 0, 0);

        repeat (2) @(negedge clk);
        check_output("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
